// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a synchronous FIFO with a one-cycle registered read latency and
//   presents its words as a valid/ready stream through a 2-entry skid buffer.
//   The stream is framed into fixed PKT_LEN-beat packets (m_last on the final
//   beat), and completed packets are counted.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after an accepted fifo_rd_en
//   fifo_rd_en  FIFO pop request
//   m_valid     stream data valid
//   m_ready     downstream ready
//   m_data      stream data (head of skid buffer)
//   m_last      last beat of packet, qualified by m_valid
//   pkt_count   completed packets, wraps modulo 2^CNT_WIDTH

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;   // head entry
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;   // second entry
    logic                  pop;
    logic                  push;
    logic [2:0]            level_after;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf0_q;
    assign m_last    = m_valid & (beat_q == BEAT_LAST);
    assign pkt_count = pkt_q;
    assign pop       = m_valid & m_ready;
    assign push      = inflight_q;

    // Occupancy once this cycle's arrival and pop settle. A new pop lands one
    // cycle later, so it may only be issued while that level leaves a free slot
    // even if the downstream stalls next cycle.
    assign level_after = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en  = rst_n & ~fifo_empty & (level_after < 3'd2);

    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) buf0_d = fifo_data;
                else               buf1_d = fifo_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Arrival always goes to the tail; never bypasses to the head.
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_d = beat_q;
        pkt_d  = pkt_q;
        if (pop) begin
            if (beat_q == BEAT_LAST) begin
                beat_d = '0;
                pkt_d  = pkt_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            pkt_q      <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

endmodule
